cla_sub_16_pipe: RTL and testbench
==================================

// Module: cla_sub_16_pipe
// PURPOSE
//  Pipelined 16-bit subtractor: D = A - B - Bin, returning borrow-out and status flags.
//  Pairs with the combinational 16-bit carry-lookahead adder in the datapath library.
//  One 4-bit lookahead slice is evaluated per stage, and the carry is registered between stages.
//  Valid/ready on input and output, so the block drops into the streaming ALU path.
// PARAMETERS
//  WIDTH   16  operand width; must be a multiple of SLICE
//  SLICE   4   bits per pipeline stage
//  STAGES  WIDTH/SLICE (4); localparam, derived, not overridable
// PORTS
//  clk        in   1      single clock; every register updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      operand beat accepted when in_valid & in_ready
//  in_a       in   WIDTH  minuend
//  in_b       in   WIDTH  subtrahend
//  in_bin     in   1      borrow-in
//  out_valid  out  1      result beat offered
//  out_ready  in   1      result beat consumed when out_valid & out_ready
//  out_d      out  WIDTH  difference, modulo 2^WIDTH
//  out_bout   out  1      borrow-out (1 = unsigned A < B + Bin)
//  out_zero   out  1      out_d == 0
//  out_neg    out  1      out_d[WIDTH-1]
//  out_ovf    out  1      signed overflow (carry into MSB XOR carry out of MSB)
// BEHAVIOUR
//  - Arithmetic: A + ~B + ~Bin.
//    - Stage k adds nibble k with carry-in c[k]; c[0] = ~in_bin.
//    - out_bout = ~c[STAGES].
//  - Skew and deskew:
//    - Stage k holds the unprocessed upper nibbles of A and B.
//    - Stage k also holds the finished lower nibbles of D and the registered carry c[k+1].
//    - The last stage also registers the carry into the MSB, used for out_ovf.
//  - Per-stage valid v[k]. Stage k loads when ~v[k] | load[k+1].
//    - load[STAGES] = out_ready.
//    - in_ready = ~v[0] | load[1]. in_ready is combinational from out_ready.
//  - Latency: 4 cycles from the accept edge to out_valid, with no stall.
//  - Throughput: 1 beat/cycle while out_ready = 1.
//  - Capacity: 4 beats in flight. With out_ready = 0 and all v set, in_ready = 0.
//  - Stall: out_d and out_* hold stable while out_valid & ~out_ready. Bubbles collapse.
//  - Ordering: strict FIFO. No beat is dropped or duplicated.
//  - Simultaneous accept at input and consume at output with a full pipe: both occur and occupancy is unchanged.
//  - Reset:
//    - All v[k] = 0. Every data/carry register is cleared to 0.
//    - out_valid = 0, out_d = 0, out_bout = 0, out_zero = 0, out_neg = 0, out_ovf = 0.
//    - in_ready = 1 from the first cycle after rst deasserts.
//  - Reset mid-operation: in-flight beats are discarded. out_valid is 0 the cycle after rst.
//  - Flags are registered with out_d. Every output is driven directly by a register.
//  - A beat offered with in_valid = 0 has no effect. Operand values are don't-care while in_valid = 0.
// STRUCTURE
//  - Shared package cla_pkg:
//    - CLA_WIDTH = 16, CLA_SLICE = 4.
//    - typedef cla_word_t [15:0], typedef cla_nib_t [3:0].
//    - Flag struct {bout, zero, neg, ovf}.
//  - One sub-module: cla_sub_slice_4.
//    - Combinational 4-bit lookahead over (a, ~b, cin).
//    - Returns {sum, cout, c3} and group P/G.
//    - Instantiated STAGES times by generate.
//  - Top level holds only the stage registers, valid/load chain and flag logic.
// TESTING
//  1. A=0x0005, B=0x0003, Bin=0, out_ready=1.
//     -> 4 cycles later: D=0x0002, bout=0, zero=0, neg=0, ovf=0.
//  2. A=0x0000, B=0x0001, Bin=0.
//     -> D=0xFFFF, bout=1, neg=1, ovf=0.
//  3. A=0x8000, B=0x0001, Bin=0.
//     -> D=0x7FFF, ovf=1, bout=0, neg=0.
//     A=0x7FFF, B=0xFFFF -> D=0x8000, ovf=1, bout=1.
//  4. A=0x1234, B=0x1233, Bin=1.
//     -> D=0x0000, zero=1, bout=0.
//     A=0xFFFF, B=0xFFFF, Bin=1 -> D=0xFFFF, bout=1.
//  5. 8 back-to-back beats, out_ready held 0 for 6 cycles then 1.
//     -> in_ready drops after the 4th accept. Held output is stable.
//     -> All 8 results arrive in order against a reference model; no loss or duplicate.
//  6. rst pulsed for 1 cycle with 3 beats in flight.
//     -> out_valid=0 and all outputs 0 the next cycle; no stale beat ever appears.
//     -> in_ready=1 next cycle.

Source files
------------

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared types and constants for the carry-lookahead datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_SLICE = 4;

    typedef logic [CLA_WIDTH-1:0] cla_word_t;
    typedef logic [CLA_SLICE-1:0] cla_nib_t;

    typedef struct packed {
        logic bout;
        logic zero;
        logic neg;
        logic ovf;
    } cla_flags_t;

    // Bit offset of stage k's pending-subtrahend field inside the packed skew store;
    // stage k keeps width - slice*(k+1) bits, so offsets are a triangular sum.
    function automatic int cla_b_off(input int k, input int stages, input int slice);
        return slice * (k * stages - (k * (k + 1)) / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_sub_slice_4.sv
`default_nettype none
// ============================================================================
// Module      : cla_sub_slice_4
// Description : Combinational 4-bit lookahead over (a, ~b, cin) with group P/G.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_sub_slice_4
    import cla_pkg::*;
(
    input  cla_nib_t a_i,
    input  cla_nib_t b_i,
    input  logic     cin_i,
    output cla_nib_t sum_o,
    output logic     cout_o,
    output logic     c3_o,
    output logic     p_o,
    output logic     g_o
);

    cla_nib_t w_bn;
    cla_nib_t w_p;
    cla_nib_t w_g;
    logic     w_c1;
    logic     w_c2;
    logic     w_c3;

    assign w_bn = ~b_i;
    assign w_p  = a_i ^ w_bn;
    assign w_g  = a_i & w_bn;

    assign w_c1 = w_g[0] | (w_p[0] & cin_i);
    assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin_i);
    assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin_i);

    assign p_o = &w_p;
    assign g_o = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign sum_o  = w_p ^ {w_c3, w_c2, w_c1, cin_i};
    assign cout_o = g_o | (p_o & cin_i);
    assign c3_o   = w_c3;

endmodule
`default_nettype wire

// File: rtl/cla_sub_16_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_sub_16_pipe
// Description : Valid/ready pipelined subtractor D = A - B - Bin, one nibble per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_sub_16_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int SLICE = CLA_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int BW     = SLICE * STAGES * (STAGES - 1) / 2;

    // The A/D word rotates right one nibble per stage, so the next unprocessed
    // minuend nibble is always at the bottom and D is complete after the last stage.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  word_q [STAGES];
    logic [STAGES-2:0] c_q;
    logic [BW-1:0]     b_q;
    cla_flags_t        flags_q;

    logic [STAGES:0]   w_en;
    logic [STAGES-1:0] w_pv;
    logic [STAGES-1:0] w_ld;
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_c3;
    logic [STAGES-1:0] w_p;
    logic [STAGES-1:0] w_g;
    logic [WIDTH-1:0]  w_word_d [STAGES];
    logic [BW-1:0]     w_b_d;
    logic [BW-1:0]     w_bmask;
    cla_flags_t        w_flags_d;
    logic              w_unused;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM_IN = WIDTH - SLICE * k;

        logic [WIDTH-1:0]  w_src;
        logic [REM_IN-1:0] w_bsrc;
        cla_nib_t          w_sum;

        if (k == 0) begin : g_first
            assign w_src    = in_a;
            assign w_bsrc   = in_b;
            assign w_cin[k] = ~in_bin;
            assign w_pv[k]  = in_valid;
        end else begin : g_next
            localparam int OFF_IN = cla_b_off(k - 1, STAGES, SLICE);
            assign w_src    = word_q[k-1];
            assign w_bsrc   = b_q[OFF_IN +: REM_IN];
            assign w_cin[k] = c_q[k-1];
            assign w_pv[k]  = v_q[k-1];
        end

        cla_sub_slice_4 u_slice (
            .a_i    (w_src[SLICE-1:0]),
            .b_i    (w_bsrc[SLICE-1:0]),
            .cin_i  (w_cin[k]),
            .sum_o  (w_sum),
            .cout_o (w_cout[k]),
            .c3_o   (w_c3[k]),
            .p_o    (w_p[k]),
            .g_o    (w_g[k])
        );

        assign w_word_d[k] = {w_sum, w_src[WIDTH-1:SLICE]};

        if (k < STAGES - 1) begin : g_fwd
            localparam int OFF = cla_b_off(k, STAGES, SLICE);
            assign w_b_d[OFF +: REM_IN-SLICE]   = w_bsrc[REM_IN-1:SLICE];
            assign w_bmask[OFF +: REM_IN-SLICE] = {(REM_IN-SLICE){w_ld[k]}};
        end else begin : g_last
            assign w_flags_d.bout = ~w_cout[k];
            assign w_flags_d.zero = (w_word_d[k] == '0);
            assign w_flags_d.neg  = w_word_d[k][WIDTH-1];
            assign w_flags_d.ovf  = w_c3[k] ^ w_cout[k];
        end
    end

    // Group P/G and the inner carries of non-final slices are not needed here.
    assign w_unused = ^{w_c3[STAGES-2:0], w_p, w_g};

    // A stage may load when empty or when its successor is loading this cycle.
    always_comb begin
        w_en         = '0;
        w_en[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_en[k] = ~v_q[k] | w_en[k+1];
        end
    end

    assign w_ld = w_en[STAGES-1:0] & w_pv;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q     <= '0;
            c_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_en[k]) begin
                    v_q[k] <= w_pv[k];
                end
                if (w_ld[k]) begin
                    word_q[k] <= w_word_d[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (w_ld[k]) begin
                    c_q[k] <= w_cout[k];
                end
            end
            b_q <= (b_q & ~w_bmask) | (w_b_d & w_bmask);
            if (w_ld[STAGES-1]) begin
                flags_q <= w_flags_d;
            end
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = v_q[STAGES-1];
    assign out_d     = word_q[STAGES-1];
    assign out_bout  = flags_q.bout;
    assign out_zero  = flags_q.zero;
    assign out_neg   = flags_q.neg;
    assign out_ovf   = flags_q.ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_sub_16_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_sub_16_pipe
// Description : Self-checking bench for cla_sub_16_pipe with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_sub_16_pipe;
    import cla_pkg::*;

    typedef struct {
        cla_word_t a;
        cla_word_t b;
        logic      bin;
        cla_word_t d;
        logic      bout;
        logic      zero;
        logic      neg;
        logic      ovf;
    } vec_t;

    typedef struct {
        cla_word_t d;
        logic      bout;
        logic      zero;
        logic      neg;
        logic      ovf;
    } exp_t;

    logic      clk;
    logic      rst;
    logic      in_valid;
    logic      in_ready;
    cla_word_t in_a;
    cla_word_t in_b;
    logic      in_bin;
    logic      out_valid;
    logic      out_ready;
    cla_word_t out_d;
    logic      out_bout;
    logic      out_zero;
    logic      out_neg;
    logic      out_ovf;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    cla_sub_16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_bout  (out_bout),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // Unsigned 17-bit reference; overflow from operand and result signs.
    function automatic exp_t model(input cla_word_t a, input cla_word_t b, input logic bin);
        logic [16:0] r;
        exp_t        e;
        r      = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        e.d    = r[15:0];
        e.bout = r[16];
        e.zero = (r[15:0] == 16'h0000);
        e.neg  = r[15];
        e.ovf  = (a[15] != b[15]) && (r[15] != a[15]);
        return e;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input cla_word_t act, input cla_word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input cla_word_t a, input cla_word_t b, input logic bin, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 for 50 cycles, expected 1");
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard monitor: a held beat must match the head, a consumed beat pops it.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got d=%h, expected no output beat", out_d);
            end else begin
                if ({out_d, out_bout, out_zero, out_neg, out_ovf} !==
                    {sb[0].d, sb[0].bout, sb[0].zero, sb[0].neg, sb[0].ovf}) begin
                    errors++;
                    $display("FAIL %s: got d=%h bout=%b zero=%b neg=%b ovf=%b, expected d=%h bout=%b zero=%b neg=%b ovf=%b",
                             out_ready ? "result" : "held_result",
                             out_d, out_bout, out_zero, out_neg, out_ovf,
                             sb[0].d, sb[0].bout, sb[0].zero, sb[0].neg, sb[0].ovf);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    vec_t tab[12];

    function automatic exp_t tab_exp(input vec_t v);
        exp_t e;
        e.d    = v.d;
        e.bout = v.bout;
        e.zero = v.zero;
        e.neg  = v.neg;
        e.ovf  = v.ovf;
        return e;
    endfunction

    initial begin
        cla_word_t va [8];
        cla_word_t vb [8];
        logic      vbin [8];
        int        n;
        int        idx;
        int        occ;
        int        cyc;
        logic      acc;
        logic      con;
        time       t0;
        cla_word_t ra;
        cla_word_t rb;
        logic      rbin;

        //          a         b         bin   d         bout  zero  neg   ovf
        tab[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[2]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[3]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
        tab[4]  = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tab[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[8]  = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tab[9]  = '{16'h00F0, 16'h0010, 1'b1, 16'h00DF, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[10] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[11] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_bit ("rst_out_valid", out_valid, 1'b0);
        check_word("rst_out_d",     out_d,     16'h0000);
        check_bit ("rst_out_bout",  out_bout,  1'b0);
        check_bit ("rst_out_zero",  out_zero,  1'b0);
        check_bit ("rst_out_neg",   out_neg,   1'b0);
        check_bit ("rst_out_ovf",   out_ovf,   1'b0);
        check_bit ("rst_in_ready",  in_ready,  1'b1);

        // Single beat: count edges from accept (inclusive) until out_valid rises.
        send(tab[0].a, tab[0].b, tab[0].bin, tab_exp(tab[0]));
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_int("latency_edges", n, 4);
        drain("latency");

        foreach (tab[i]) begin
            send(tab[i].a, tab[i].b, tab[i].bin, tab_exp(tab[i]));
        end
        in_valid = 1'b0;
        drain("table");

        // Full-rate streaming: 20 beats must be accepted in 20 cycles.
        t0 = $time;
        for (int i = 0; i < 20; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            send(ra, rb, rbin, model(ra, rb, rbin));
        end
        in_valid = 1'b0;
        check_int("throughput_cycles", int'(($time - t0) / 10), 20);
        drain("stream");

        // Backpressure: out_ready low for 6 cycles while 8 beats are offered.
        for (int i = 0; i < 8; i++) begin
            va[i]   = 16'($urandom);
            vb[i]   = 16'($urandom);
            vbin[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        occ = 0;
        cyc = 0;
        while ((idx < 8 || sb.size() != 0) && cyc < 60) begin
            out_ready = (cyc >= 6);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                in_a   = va[idx];
                in_b   = vb[idx];
                in_bin = vbin[idx];
            end
            @(negedge clk);
            check_bit($sformatf("stall_in_ready_c%0d", cyc), in_ready, (occ < 4) || out_ready);
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (acc) begin
                sb.push_back(model(va[idx], vb[idx], vbin[idx]));
                idx++;
            end
            occ = occ + int'(acc) - int'(con);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_int("stall_accepted", idx, 8);
        drain("stall");

        // Random backpressure and input gaps; ordering checked by the scoreboard.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    ra   = 16'($urandom);
                    rb   = 16'($urandom);
                    rbin = 1'($urandom_range(0, 1));
                    send(ra, rb, rbin, model(ra, rb, rbin));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
            end
            begin
                repeat (120) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("random");

        // Reset with three beats in flight: none of them may ever appear.
        for (int i = 0; i < 3; i++) begin
            ra = 16'h1111 * 16'(i + 1);
            send(ra, 16'h0001, 1'b0, model(ra, 16'h0001, 1'b0));
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_bit ("midrst_out_valid", out_valid, 1'b0);
        check_word("midrst_out_d",     out_d,     16'h0000);
        check_bit ("midrst_out_bout",  out_bout,  1'b0);
        check_bit ("midrst_out_zero",  out_zero,  1'b0);
        check_bit ("midrst_out_neg",   out_neg,   1'b0);
        check_bit ("midrst_out_ovf",   out_ovf,   1'b0);
        check_bit ("midrst_in_ready",  in_ready,  1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check_bit($sformatf("midrst_no_stale_%0d", i), out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
